ball_render: RTL
================

BALL_RENDER -- requirements
Module: ball_render

Interface
REQ-001 SHALL have parameter BALL_SIZE, default 4: ball side length in pixels, legal 1..15.
REQ-002 SHALL have parameter H_RES, default 640: visible width; pixels with x >= H_RES are clipped.
REQ-003 SHALL have parameter V_RES, default 480: visible height; pixels with y >= V_RES are clipped.
REQ-004 SHALL have parameter BALL_COLOUR, default 3'b111: draw colour.
REQ-005 SHALL have parameter BG_COLOUR, default 3'b000: erase colour.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: request to render the ball at new_x/new_y.
REQ-009 SHALL have port new_x, input, 10 bits: top-left X of the new ball position, from the position-update stage.
REQ-010 SHALL have port new_y, input, 10 bits: top-left Y of the new ball position.
REQ-011 SHALL have port vga_x, output, 10 bits: pixel X to the VGA adapter.
REQ-012 SHALL have port vga_y, output, 10 bits: pixel Y to the VGA adapter.
REQ-013 SHALL have port vga_colour, output, 3 bits: pixel colour.
REQ-014 SHALL have port vga_plot, output, 1 bit: write strobe, one pixel per cycle.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when rendering completes.

Function
REQ-017 SHALL implement FSM states IDLE, ERASE, DRAW, DONE.
REQ-018 SHALL, in IDLE with start=1, capture new_x/new_y; next state is ERASE if old_valid=1, else DRAW.
REQ-019 SHALL ignore start in every state other than IDLE; captured coordinates stay stable for the whole operation.
REQ-020 SHALL scan BALL_SIZE*BALL_SIZE pixels per ERASE or DRAW pass at one pixel per cycle, in raster order: dx 0..BALL_SIZE-1 inner, dy outer.
REQ-021 SHALL present, during a pass, vga_x = base_x+dx and vga_y = base_y+dy, truncated to 10 bits (wrap, no saturation).
REQ-022 SHALL use the stored old position as base in ERASE with vga_colour=BG_COLOUR, and the captured position in DRAW with vga_colour=BALL_COLOUR.
REQ-023 SHALL drive vga_plot=1 for each in-range pixel; a pixel with vga_x>=H_RES or vga_y>=V_RES SHALL get vga_plot=0 but still consume its cycle.
REQ-024 SHALL go ERASE->DRAW and DRAW->DONE on the cycle after the last pixel (dx=dy=BALL_SIZE-1), then DONE->IDLE unconditionally.
REQ-025 SHALL, in DONE, assert done=1, copy the captured position into the old position, and set old_valid=1.
REQ-026 SHALL give this timing when start is accepted at edge t: pixels on cycles t+1 .. t+N (without erase) or t+1 .. t+2N (with erase), where N = BALL_SIZE squared; done follows in the next cycle.
REQ-027 SHALL hold vga_plot=0 in IDLE and DONE; vga_x/vga_y/vga_colour are don't-care when vga_plot=0.

Reset
REQ-028 SHALL, when resetn=0, enter IDLE immediately regardless of clk, including mid-pass.
REQ-029 SHALL, on reset, set vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0, pixel counters=0, old position=0, and old_valid=0.
REQ-030 SHALL skip ERASE on the first accepted start after any reset.

Configuration
REQ-031 SHALL support macro BALL_ERASE_EN; when defined, ERASE behaves per REQ-018/022.
REQ-032 SHALL, when BALL_ERASE_EN is undefined, compile out ERASE and the old-position registers; IDLE always goes to DRAW, latency is always N, and old_valid need not exist.

Verification (BALL_SIZE=4, BALL_ERASE_EN defined unless noted)
REQ-033 SHALL cover: reset, then start with new_x=100, new_y=50 -> 16 plots with colour 3'b111 at (100..103, 50..53), raster order, cycles t+1..t+16, done at t+17.
REQ-034 SHALL cover: a second start with new_x=101, new_y=51 -> 16 BG_COLOUR plots at (100..103, 50..53), then 16 BALL_COLOUR plots at (101..104, 51..54), done at t+33.
REQ-035 SHALL cover: start with new_x=638, new_y=478 -> vga_plot=0 for x in 640..641 or y in 480..481; 4 plots total; done still at t+17.
REQ-036 SHALL cover: start pulsed again on cycles t+5 and t+17 of an operation -> ignored; no change in the pixel sequence or the captured coordinates.
REQ-037 SHALL cover: resetn low at cycle t+8 of an operation -> outputs zero immediately; next start with (10,10) draws without erase.
REQ-038 SHALL cover: with BALL_ERASE_EN undefined, two starts (100,50) then (101,51) -> each produces only 16 draw plots, done at t+17.

Source files
------------

// File: rtl/ball_render.sv
// rtl/ball_render.sv - square ball renderer: optional erase of the old ball, then draw of the new one
//
// Purpose: on an accepted start, scans a BALL_SIZE x BALL_SIZE square one pixel
// per cycle in raster order (dx inner, dy outer). Pixels that fall outside the
// visible area are skipped (no plot) but still take their cycle.
// Optional feature macro: BALL_ERASE_EN. When it is defined, the previous ball
// is first painted with BG_COLOUR. Without it, only the draw pass exists.
//
// Ports:
//   clk         in   single clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   render request, sampled only in IDLE
//   new_x/new_y in   top-left corner of the new ball position (10 bits each)
//   vga_x/vga_y out  pixel coordinate to the VGA adapter (10 bits each)
//   vga_colour  out  pixel colour (3 bits)
//   vga_plot    out  pixel write strobe
//   busy        out  high whenever the FSM is not in IDLE
//   done        out  one-cycle completion pulse
module ball_render #(
  parameter int         BALL_SIZE   = 4,
  parameter int         H_RES       = 640,
  parameter int         V_RES       = 480,
  parameter logic [2:0] BALL_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [9:0] new_x,
  input  logic [9:0] new_y,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  localparam logic [3:0]  LP_LAST = 4'(BALL_SIZE - 1);
  localparam logic [10:0] LP_HRES = 11'(H_RES);
  localparam logic [10:0] LP_VRES = 11'(V_RES);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_dx;
  logic [3:0] r_dy;
  logic [9:0] r_cur_x;
  logic [9:0] r_cur_y;
  logic [9:0] w_base_x;
  logic [9:0] w_base_y;
  logic [9:0] w_px;
  logic [9:0] w_py;
  logic       w_pass;
  logic       w_last;

`ifdef BALL_ERASE_EN
  logic [9:0] r_old_x;
  logic [9:0] r_old_y;
  logic       r_old_valid;
`endif

  assign w_pass = (r_state == ERASE) || (r_state == DRAW);
  assign w_last = (r_dx == LP_LAST) && (r_dy == LP_LAST);
  // Coordinates wrap at 10 bits; the range check below then clips them.
  assign w_px   = w_base_x + {6'd0, r_dx};
  assign w_py   = w_base_y + {6'd0, r_dy};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_base_x   = r_cur_x;
    w_base_y   = r_cur_y;
    vga_colour = 3'd0;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef BALL_ERASE_EN
          w_next = r_old_valid ? ERASE : DRAW;
`else
          w_next = DRAW;
`endif
        end
      end
`ifdef BALL_ERASE_EN
      ERASE: begin
        w_base_x   = r_old_x;
        w_base_y   = r_old_y;
        vga_colour = BG_COLOUR;
        if (w_last) w_next = DRAW;
      end
`endif
      DRAW: begin
        vga_colour = BALL_COLOUR;
        if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign vga_x    = w_pass ? w_px : 10'd0;
  assign vga_y    = w_pass ? w_py : 10'd0;
  assign vga_plot = w_pass && ({1'b0, w_px} < LP_HRES) && ({1'b0, w_py} < LP_VRES);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);

  // Pixel counters return to zero after the last pixel so the next pass
  // (draw after erase) starts at the corner without an extra cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dx <= 4'd0;
      r_dy <= 4'd0;
    end else if (w_pass) begin
      if (r_dx == LP_LAST) begin
        r_dx <= 4'd0;
        r_dy <= w_last ? 4'd0 : r_dy + 4'd1;
      end else begin
        r_dx <= r_dx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cur_x <= 10'd0;
      r_cur_y <= 10'd0;
    end else if ((r_state == IDLE) && start) begin
      r_cur_x <= new_x;
      r_cur_y <= new_y;
    end
  end

`ifdef BALL_ERASE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_old_x     <= 10'd0;
      r_old_y     <= 10'd0;
      r_old_valid <= 1'b0;
    end else if (r_state == DONE) begin
      r_old_x     <= r_cur_x;
      r_old_y     <= r_cur_y;
      r_old_valid <= 1'b1;
    end
  end
`endif

endmodule
